mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// Shares the single byte-serial memory controller between three requesters: instruction fetch (IF), data load (LD), data store (ST).
// Latches one request per transaction, drives the controller's request bundle, waits for completion, then returns a one-cycle done with data to the winner.
// Priority ST > LD > IF, with a starvation guard for IF, a pipeline-flush squash and an IO-full store hold.
// PARAMETERS
// ADDR_W      32  address width
// STARVE_MAX  4   consecutive non-IF grants while if_req is high before IF is forced first (1..15)
// STAT_W      16  width of statistics counters (MEM_ARB_STAT_EN only)
// PORTS
// clk            in   1       clock
// rst            in   1       synchronous, active-high reset
// rdy            in   1       global enable; low = freeze all state, outputs hold
// clr            in   1       pipeline flush (mispredict)
// io_full        in   1       IO output buffer full
// if_req/if_addr in   1/ADDR_W  fetch request, 4-byte read
// if_done        out  1       fetch complete pulse
// ld_req/ld_addr in   1/ADDR_W  load request
// ld_len         in   3       bytes: 1, 2 or 4
// ld_done        out  1       load complete pulse
// st_req/st_addr in   1/ADDR_W  store request
// st_len         in   3       bytes: 1, 2 or 4
// st_data        in   32      store data, little-endian
// st_done        out  1       store complete pulse
// rdata          out  32      read data, valid with if_done/ld_done
// mc_en          out  1       request to memory controller
// mc_ls          out  1       0 = load/read, 1 = store
// mc_len         out  3       byte count
// mc_addr        out  ADDR_W  start address
// mc_wdata       out  32      store data
// mc_done        in   1       controller completion pulse
// mc_rdata       in   32      controller read data, valid with mc_done
// BEHAVIOUR
// - Reset: state IDLE; all done, mc_en, mc_ls = 0; mc_len/mc_addr/mc_wdata/rdata = 0; starve_cnt = 0; squash = 0.
// - Handshake: requester holds req and fields stable until its done; must drop req in the cycle after done.
// - FSM IDLE -> BUSY -> RESP -> IDLE; rdy low freezes every register.
// - IDLE: ST eligible if st_req and not (io_full and st_addr[17:16]==2'b11); pick by priority; latch fields, owner, go BUSY.
//   If starve_cnt == STARVE_MAX and if_req, IF wins regardless. No eligible req: stay IDLE.
// - BUSY: mc_en=1 with latched bundle, stable; on mc_done capture mc_rdata into rdata, mc_en=0 same cycle, go RESP.
// - RESP: pulse owner's done for exactly one cycle (suppressed if squash); clear squash; go IDLE.
// - Latency: req seen at edge N -> mc_en from N+1; mc_done at cycle M -> done at M+1; next grant sampled M+2.
// - starve_cnt: +1 (saturating at STARVE_MAX) on each LD/ST grant while if_req high; 0 on IF grant or if_req low in IDLE.
// - clr: owner IF/LD in BUSY or RESP -> squash=1 (RESP: done suppressed that cycle); controller transaction still completes (no abort).
//   owner ST: unaffected, st_done delivered. clr in IDLE: nothing granted that cycle (IF and LD ignored; ST may grant).
// - rdata for stores = 0; ld_len/st_len not in {1,2,4}: forwarded unchanged (caller's error).
// - rst mid-transaction: immediate return to reset state; in-flight controller op is abandoned (controller reset together).
// CONFIGURATION
// MEM_ARB_STAT_EN defined: adds outputs stat_if, stat_ld, stat_st, stat_stall (STAT_W each): grant counts per
//   requester and cycles ST held by io_full; wrap on overflow; cleared by rst.
// MEM_ARB_STAT_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - if_req, addr 0x1000 alone; mc_done 3 cycles after mc_en with 0xDEADBEEF -> mc_ls=0, mc_len=4, if_done 1 cycle later, rdata=0xDEADBEEF.
// - if_req, ld_req, st_req same cycle -> grant order ST, LD, IF; exactly one done per transaction; no two mc_en overlap.
// - st_req addr 0x30000, io_full=1, ld_req pending -> LD granted; ST granted only in first IDLE after io_full drops.
// - if_req held, LD/ST re-requested back-to-back, STARVE_MAX=4 -> IF granted after 4th non-IF grant, starve_cnt back to 0.
// - clr during BUSY of LD -> mc_done still consumed, ld_done never asserted, next grant proceeds normally.
// - rst asserted in BUSY -> next cycle mc_en=0, all done=0, state IDLE; with MEM_ARB_STAT_EN all stat_* read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - ST > LD > IF arbiter for the shared byte-serial memory controller
// Optional grant/stall statistics: define MEM_ARB_STAT_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              io_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_done,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic [31:0]       rdata,
  output logic              mc_en,
  output logic              mc_ls,
  output logic [2:0]        mc_len,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_wdata,
`ifdef MEM_ARB_STAT_EN
  output logic [STAT_W-1:0] stat_if,
  output logic [STAT_W-1:0] stat_ld,
  output logic [STAT_W-1:0] stat_st,
  output logic [STAT_W-1:0] stat_stall,
`endif
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || STAT_W < 1 || ADDR_W < 18) begin : g_param_check
    $error("mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t     state, state_nx;
  owner_t     owner, grant_owner;
  logic       grant;
  logic [3:0] starve_cnt;
  logic       squash;

  // Stores into the IO window (addr[17:16]==3) wait while the IO buffer is full.
  logic st_blocked, st_ok, if_ok, ld_ok, force_if;
  assign st_blocked = io_full && (st_addr[17:16] == 2'b11);
  assign st_ok      = st_req && !st_blocked;
  assign if_ok      = if_req && !clr;
  assign ld_ok      = ld_req && !clr;
  assign force_if   = if_ok && (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_IF;
    if (force_if) begin
      grant       = 1'b1;
      grant_owner = OWN_IF;
    end else if (st_ok) begin
      grant       = 1'b1;
      grant_owner = OWN_ST;
    end else if (ld_ok) begin
      grant       = 1'b1;
      grant_owner = OWN_LD;
    end else if (if_ok) begin
      grant       = 1'b1;
      grant_owner = OWN_IF;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant) state_nx = S_BUSY;
      S_BUSY:  if (mc_done) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else if (rdy) state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_IF;
      mc_ls      <= 1'b0;
      mc_len     <= 3'd0;
      mc_addr    <= '0;
      mc_wdata   <= 32'd0;
      rdata      <= 32'd0;
      starve_cnt <= 4'd0;
      squash     <= 1'b0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner <= grant_owner;
            case (grant_owner)
              OWN_ST: begin
                mc_ls    <= 1'b1;
                mc_len   <= st_len;
                mc_addr  <= st_addr;
                mc_wdata <= st_data;
              end
              OWN_LD: begin
                mc_ls    <= 1'b0;
                mc_len   <= ld_len;
                mc_addr  <= ld_addr;
                mc_wdata <= 32'd0;
              end
              default: begin
                mc_ls    <= 1'b0;
                mc_len   <= 3'd4;
                mc_addr  <= if_addr;
                mc_wdata <= 32'd0;
              end
            endcase
          end
          if ((grant && grant_owner == OWN_IF) || !if_req) starve_cnt <= 4'd0;
          else if (grant && starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
        end
        S_BUSY: begin
          // A flushed fetch/load still runs to completion; only its done is dropped.
          if (clr && owner != OWN_ST) squash <= 1'b1;
          if (mc_done) rdata <= (owner == OWN_ST) ? 32'd0 : mc_rdata;
        end
        S_RESP:  squash <= 1'b0;
        default: ;
      endcase
    end
  end

  logic resp_ok;
  assign resp_ok = (state == S_RESP) && !squash && !(rdy && clr && owner != OWN_ST);
  assign mc_en   = (state == S_BUSY);
  assign if_done = resp_ok && (owner == OWN_IF);
  assign ld_done = resp_ok && (owner == OWN_LD);
  assign st_done = resp_ok && (owner == OWN_ST);

`ifdef MEM_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if    <= '0;
      stat_ld    <= '0;
      stat_st    <= '0;
      stat_stall <= '0;
    end else if (rdy && state == S_IDLE) begin
      if (grant) begin
        case (grant_owner)
          OWN_ST:  stat_st <= stat_st + STAT_W'(1);
          OWN_LD:  stat_ld <= stat_ld + STAT_W'(1);
          default: stat_if <= stat_if + STAT_W'(1);
        endcase
      end
      if (st_req && st_blocked) stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`endif

endmodule
